// File: rtl/rob_allocator.sv
// ROB entry allocator: grants WIDTH consecutive entry IDs per dispatch group, retires from head, flush rewinds tail.
// Optional ROB_ALLOCATOR_STATS_EN adds a saturating stall_cycles counter; alloc_ready uses registered occupancy only.
module rob_allocator #(
  parameter int WIDTH       = 4,
  parameter int ROB_ENTRIES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid,
  output logic                 alloc_ready,
  output logic [5*WIDTH-1:0]   alloc_entries,
  input  logic [2:0]           commit_count,
  input  logic                 flush,
  output logic [4:0]           head,
  output logic [5:0]           free_count,
  output logic                 empty,
  output logic                 full
`ifdef ROB_ALLOCATOR_STATS_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  typedef enum logic [1:0] {INIT, RUN, FLUSH} state_t;

  localparam logic [4:0] PTR_MASK = 5'(ROB_ENTRIES - 1);
  localparam logic [5:0] GROUP    = 6'(WIDTH);
  localparam logic [5:0] DEPTH    = 6'(ROB_ENTRIES);

  state_t     state;
  logic [4:0] tail;
  logic [5:0] count;
  logic [5:0] commit_req;
  logic [5:0] commit_amt;
  logic       grant;

  assign free_count  = DEPTH - count;
  assign empty       = (count == 6'd0);
  assign full        = (free_count < GROUP);
  assign alloc_ready = (state == RUN) && (free_count >= GROUP);
  assign grant       = alloc_valid && alloc_ready;

  // Retire no more than is actually allocated; excess commit_count is clamped.
  assign commit_req = {3'b000, commit_count};
  assign commit_amt = (commit_req > count) ? count : commit_req;

  always_comb begin
    alloc_entries = '0;
    for (int i = 0; i < WIDTH; i++) begin
      alloc_entries[5*i +: 5] = (tail + 5'(i)) & PTR_MASK;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT;
      head  <= 5'd0;
      tail  <= 5'd0;
      count <= 6'd0;
    end else begin
      case (state)
        INIT: state <= RUN;
        RUN: begin
          // Flush wins over any grant or commit presented in the same cycle.
          if (flush) begin
            state <= FLUSH;
          end else begin
            head  <= (head + commit_amt[4:0]) & PTR_MASK;
            if (grant) tail <= (tail + GROUP[4:0]) & PTR_MASK;
            count <= count + (grant ? GROUP : 6'd0) - commit_amt;
          end
        end
        FLUSH: begin
          tail  <= head;
          count <= 6'd0;
          state <= RUN;
        end
        default: state <= INIT;
      endcase
    end
  end

`ifdef ROB_ALLOCATOR_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= 32'd0;
    end else if ((state == RUN) && alloc_valid && !alloc_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rob_allocator.sv
// Directed bench for rob_allocator: reset, fill, commit, wrap, flush, clamp and mid-operation reset.
module tb_rob_allocator;

  logic        clk;
  logic        rst;
  logic        alloc_valid;
  logic        alloc_ready;
  logic [19:0] alloc_entries;
  logic [2:0]  commit_count;
  logic        flush;
  logic [4:0]  head;
  logic [5:0]  free_count;
  logic        empty;
  logic        full;
`ifdef ROB_ALLOCATOR_STATS_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  rob_allocator #(.WIDTH(4), .ROB_ENTRIES(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid   (alloc_valid),
    .alloc_ready   (alloc_ready),
    .alloc_entries (alloc_entries),
    .commit_count  (commit_count),
    .flush         (flush),
    .head          (head),
    .free_count    (free_count),
    .empty         (empty),
    .full          (full)
`ifdef ROB_ALLOCATOR_STATS_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed lane IDs {base+3, base+2, base+1, base} modulo 32.
  function automatic logic [31:0] lanes(input int base);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[5*i +: 5] = 5'((base + i) % 32);
    return r;
  endfunction

  initial begin
    rst = 1'b0; alloc_valid = 1'b0; commit_count = 3'd0; flush = 1'b0;
    tick(); tick();
    chk("rst_ready", 32'(alloc_ready), 0);
    chk("rst_entries", 32'(alloc_entries), lanes(0));
    chk("rst_free", 32'(free_count), 32);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_head", 32'(head), 0);

    // Release reset with alloc_valid held: one INIT cycle, then eight grants.
    rst = 1'b1; alloc_valid = 1'b1;
    chk("init_ready", 32'(alloc_ready), 0);
    tick();
    for (int g = 0; g < 8; g++) begin
      chk($sformatf("fill_ready_%0d", g), 32'(alloc_ready), 1);
      chk($sformatf("fill_entries_%0d", g), 32'(alloc_entries), lanes(4*g));
      tick();
    end
    chk("full_flag", 32'(full), 1);
    chk("full_free", 32'(free_count), 0);
    chk("full_ready", 32'(alloc_ready), 0);

    // Full ROB: commit does not raise ready in the same cycle, request ignored.
    commit_count = 3'd4;
    chk("commit_no_bypass", 32'(alloc_ready), 0);
    tick();
    chk("commit_head", 32'(head), 4);
    chk("commit_free", 32'(free_count), 4);
    chk("commit_ready", 32'(alloc_ready), 1);
    chk("commit_entries", 32'(alloc_entries), lanes(0));
    commit_count = 3'd0;
    tick();
    chk("refill_full", 32'(full), 1);
    chk("refill_entries", 32'(alloc_entries), lanes(4));

    alloc_valid = 1'b0; commit_count = 3'd4;
    repeat (5) tick();
    chk("drain_head", 32'(head), 24);
    chk("drain_free", 32'(free_count), 20);

    // Flush with a simultaneous grant request and commit: both ignored.
    flush = 1'b1; alloc_valid = 1'b1; commit_count = 3'd3;
    tick();
    chk("flush_ready", 32'(alloc_ready), 0);
    chk("flush_head", 32'(head), 24);
    chk("flush_free", 32'(free_count), 20);
    flush = 1'b0;
    tick();
    chk("post_flush_empty", 32'(empty), 1);
    chk("post_flush_ready", 32'(alloc_ready), 1);
    chk("post_flush_free", 32'(free_count), 32);
    chk("post_flush_head", 32'(head), 24);
    chk("post_flush_entries", 32'(alloc_entries), lanes(24));

    // Steer to head=28, tail=30, count=2.
    commit_count = 3'd0; alloc_valid = 1'b1;
    tick();
    chk("grant_free", 32'(free_count), 28);
    alloc_valid = 1'b0; commit_count = 3'd2;
    tick();
    commit_count = 3'd0; flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    chk("rewind_entries", 32'(alloc_entries), lanes(26));
    alloc_valid = 1'b1;
    tick();
    alloc_valid = 1'b0; commit_count = 3'd2;
    tick();
    chk("pre_wrap_head", 32'(head), 28);
    chk("pre_wrap_free", 32'(free_count), 30);

    // Grant straddling the wrap together with a commit.
    alloc_valid = 1'b1; commit_count = 3'd2;
    chk("wrap_entries", 32'(alloc_entries), 32'({5'd1, 5'd0, 5'd31, 5'd30}));
    chk("wrap_ready", 32'(alloc_ready), 1);
    tick();
    chk("wrap_head", 32'(head), 30);
    chk("wrap_free", 32'(free_count), 28);
    chk("wrap_tail_entries", 32'(alloc_entries), 32'({5'd5, 5'd4, 5'd3, 5'd2}));

    // Over-commit is clamped to occupancy.
    alloc_valid = 1'b0; commit_count = 3'd2;
    tick();
    chk("head_wrap", 32'(head), 0);
    commit_count = 3'd4;
    tick();
    chk("clamp_head", 32'(head), 2);
    chk("clamp_empty", 32'(empty), 1);
    chk("clamp_free", 32'(free_count), 32);

    // Reset mid-operation overrides flush, grant and commit.
    alloc_valid = 1'b1; commit_count = 3'd0;
    tick();
    chk("pre_rst_free", 32'(free_count), 28);
    rst = 1'b0; flush = 1'b1; commit_count = 3'd3;
    tick();
    chk("midrst_head", 32'(head), 0);
    chk("midrst_free", 32'(free_count), 32);
    chk("midrst_ready", 32'(alloc_ready), 0);
    chk("midrst_entries", 32'(alloc_entries), lanes(0));
    chk("midrst_empty", 32'(empty), 1);
    flush = 1'b0; commit_count = 3'd0;

`ifdef ROB_ALLOCATOR_STATS_EN
    chk("stall_rst", stall_cycles, 0);
    rst = 1'b1; alloc_valid = 1'b1;
    tick();
    repeat (8) tick();
    chk("stall_after_fill", stall_cycles, 0);
    repeat (5) tick();
    chk("stall_count", stall_cycles, 5);
    rst = 1'b0;
    tick();
    chk("stall_cleared", stall_cycles, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
